// File: rtl/rom_fetch.sv
// rom_fetch: byte-wide CPU read port in front of a 16-bit word memory.
//
// A one-entry word cache (valid, tag, data) serves both bytes of the most
// recently fetched word without touching memory. A miss stalls the CPU and
// issues one level-signalled word request, which completes on a single-cycle
// mem_ack. While a ROM download is in progress the cache is invalidated every
// cycle and no new request is started.
//
// Ports:
//   clk_sys    in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   cpu_addr   in   CPU byte address [ADDR_W-1:0]
//   cpu_rd     in   CPU read request (level, held while stalled)
//   cpu_dout   out  read byte, combinational from cache and cpu_addr
//   cpu_wait   out  CPU stall; cpu_dout not valid while high
//   dl_active  in   ROM download in progress
//   mem_req    out  word-read request (level)
//   mem_addr   out  word address of the request [ADDR_W-2:0]
//   mem_ack    in   one-cycle completion pulse
//   mem_din    in   read word, valid in the mem_ack cycle
module rom_fetch #(
  parameter int ADDR_W = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic              dl_active,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_din
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic              valid, valid_nxt;
  logic [ADDR_W-2:0] tag, tag_nxt;
  logic [15:0]       data, data_nxt;
  logic              req_nxt;
  logic [ADDR_W-2:0] addr_nxt;
  logic              hit;

  // Cache lookup and CPU-side outputs are purely combinational.
  assign hit      = valid & (tag == cpu_addr[ADDR_W-1:1]) & ~dl_active;
  assign cpu_wait = cpu_rd & ~hit;
  assign cpu_dout = cpu_addr[0] ? data[15:8] : data[7:0];

  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    addr_nxt  = mem_addr;
    tag_nxt   = tag;
    data_nxt  = data;
    // A download in progress kills the cached word every cycle.
    valid_nxt = valid & ~dl_active;
    case (state)
      IDLE: begin
        // mem_ack here is a stray pulse and is deliberately ignored.
        if (cpu_rd && !hit && !dl_active) begin
          state_nxt = BUSY;
          req_nxt   = 1'b1;
          addr_nxt  = cpu_addr[ADDR_W-1:1];
        end
      end
      BUSY: begin
        // The latched mem_addr is the fill target even if cpu_addr moved;
        // a download overlapping the fill leaves the entry invalid.
        if (mem_ack) begin
          data_nxt  = mem_din;
          tag_nxt   = mem_addr;
          valid_nxt = ~dl_active;
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // Returning to IDLE with mem_req low guarantees at least one low cycle
  // between consecutive requests.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      valid    <= 1'b0;
      tag      <= '0;
      data     <= '0;
    end else begin
      state    <= state_nxt;
      mem_req  <= req_nxt;
      mem_addr <= addr_nxt;
      valid    <= valid_nxt;
      tag      <= tag_nxt;
      data     <= data_nxt;
    end
  end

endmodule

// File: tb/tb_rom_fetch.sv
module tb_rom_fetch;

  localparam int AW = 15;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rd;
  logic [7:0]    cpu_dout;
  logic          cpu_wait;
  logic          dl_active;
  logic          mem_req;
  logic [AW-2:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_din;

  rom_fetch #(.ADDR_W(AW)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_rd   (cpu_rd),
    .cpu_dout (cpu_dout),
    .cpu_wait (cpu_wait),
    .dl_active(dl_active),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_din  (mem_din)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference model: cached word plus an outstanding-fill word address
  // (-1 when nothing is pending) and the last address handed to memory.
  bit            m_ok = 0;
  bit            m_valid;
  logic [AW-2:0] m_tag;
  logic [15:0]   m_data;
  int            m_pend;
  logic [AW-2:0] m_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    return m_valid && (m_tag == cpu_addr[AW-1:1]) && !dl_active;
  endfunction

  // Apply inputs shortly after a rising edge, then compare every output
  // against the model before the next edge.
  task automatic drive(input logic r, input logic [AW-1:0] a, input logic rd,
                       input logic dl, input logic ack, input logic [15:0] din);
    reset = r; cpu_addr = a; cpu_rd = rd; dl_active = dl; mem_ack = ack; mem_din = din;
    #1;
    if (m_ok) begin
      check_eq("cpu_wait", cpu_wait, rd && !model_hit());
      check_eq("cpu_dout", cpu_dout, a[0] ? m_data[15:8] : m_data[7:0]);
      check_eq("mem_req",  mem_req,  m_pend >= 0);
      check_eq("mem_addr", mem_addr, m_last);
    end
  endtask

  task automatic tick();
    bit h;
    @(posedge clk_sys);
    h = model_hit();
    if (reset) begin
      m_valid = 0; m_tag = '0; m_data = '0; m_pend = -1; m_last = '0; m_ok = 1;
    end else if (m_pend >= 0) begin
      if (mem_ack) begin
        m_data = mem_din; m_tag = m_pend[AW-2:0]; m_valid = !dl_active; m_pend = -1;
      end else begin
        m_valid = m_valid && !dl_active;
      end
    end else begin
      if (cpu_rd && !h && !dl_active) begin
        m_pend = int'(cpu_addr[AW-1:1]);
        m_last = cpu_addr[AW-1:1];
      end
      m_valid = m_valid && !dl_active;
    end
    #1;
  endtask

  initial begin
    // Reset
    drive(1, 0, 0, 0, 0, 0); tick(); tick();
    drive(0, 0, 0, 0, 0, 0);
    check_eq("rst_dout", cpu_dout, 8'h00);
    check_eq("rst_req",  mem_req, 0);
    check_eq("rst_maddr", mem_addr, 0);

    // Cold miss on byte 0x0001, ack three cycles after request
    drive(0, 15'h0001, 1, 0, 0, 0);
    check_eq("cold_wait0", cpu_wait, 1);
    tick();
    drive(0, 15'h0001, 1, 0, 0, 0);
    check_eq("cold_req", mem_req, 1);
    check_eq("cold_maddr", mem_addr, 14'h0000);
    tick();
    drive(0, 15'h0001, 1, 0, 0, 16'h1111); tick();
    drive(0, 15'h0001, 1, 0, 1, 16'hBEEF);
    check_eq("cold_wait_ack", cpu_wait, 1);
    tick();
    drive(0, 15'h0001, 1, 0, 0, 0);
    check_eq("cold_wait1", cpu_wait, 0);
    check_eq("cold_dout", cpu_dout, 8'hBE);
    check_eq("cold_reqlo", mem_req, 0);
    tick();

    // Same-word hit on the other byte
    drive(0, 15'h0000, 1, 0, 0, 0);
    check_eq("hit_wait", cpu_wait, 0);
    check_eq("hit_dout", cpu_dout, 8'hEF);
    tick();
    drive(0, 15'h0000, 1, 0, 0, 0);
    check_eq("hit_noreq", mem_req, 0);
    tick();

    // Address change mid-fill
    drive(0, 15'h0020, 1, 0, 0, 0); tick();
    drive(0, 15'h0084, 1, 0, 0, 0);
    check_eq("mid_maddr", mem_addr, 14'h0010);
    tick();
    drive(0, 15'h0084, 1, 0, 1, 16'h2233); tick();
    drive(0, 15'h0020, 1, 0, 0, 0);
    check_eq("mid_fill_tag", cpu_wait, 0);
    check_eq("mid_fill_dout", cpu_dout, 8'h33);
    drive(0, 15'h0042, 1, 0, 0, 0);
    check_eq("mid_gap", mem_req, 0);
    tick();
    drive(0, 15'h0042, 1, 0, 0, 0);
    check_eq("mid_req2", mem_req, 1);
    check_eq("mid_maddr2", mem_addr, 14'h0021);
    tick();
    drive(0, 15'h0042, 1, 0, 1, 16'h4455); tick();

    // Download invalidation
    drive(0, 15'h0042, 1, 0, 0, 0);
    check_eq("dl_prehit", cpu_wait, 0);
    tick();
    drive(0, 15'h0042, 1, 1, 0, 0);
    check_eq("dl_wait", cpu_wait, 1);
    tick();
    drive(0, 15'h0042, 1, 1, 0, 0);
    check_eq("dl_noreq", mem_req, 0);
    tick();
    drive(0, 15'h0042, 1, 0, 0, 0);
    check_eq("dl_miss", cpu_wait, 1);
    tick();
    drive(0, 15'h0042, 1, 1, 1, 16'h6677);
    check_eq("dl_busyreq", mem_req, 1);
    tick();
    drive(0, 15'h0042, 1, 0, 0, 0);
    check_eq("dl_fill_invalid", cpu_wait, 1);
    tick();
    drive(0, 15'h0042, 1, 0, 1, 16'h6677); tick();

    // Reset mid-request, late ack ignored
    drive(0, 15'h0100, 1, 0, 0, 0); tick();
    drive(1, 15'h0100, 1, 0, 0, 0); tick();
    drive(0, 15'h0100, 0, 0, 0, 0);
    check_eq("rstb_req", mem_req, 0);
    tick();
    drive(0, 15'h0100, 0, 0, 1, 16'hABCD); tick();
    drive(0, 15'h0100, 0, 0, 0, 0);
    check_eq("rstb_dout", cpu_dout, 8'h00);
    check_eq("rstb_req2", mem_req, 0);
    drive(0, 15'h0100, 1, 0, 0, 0);
    check_eq("rstb_invalid", cpu_wait, 1);
    tick();
    drive(0, 15'h0100, 1, 0, 1, 16'h5AA5); tick();

    // Stray ack in IDLE
    drive(0, 15'h0100, 0, 0, 1, 16'h1234); tick();
    drive(0, 15'h0100, 1, 0, 0, 0);
    check_eq("stray_wait", cpu_wait, 0);
    check_eq("stray_dout", cpu_dout, 8'hA5);
    check_eq("stray_req", mem_req, 0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 300) == 0, AW'($urandom % 8), ($urandom % 4) != 0,
            ($urandom % 20) == 0, ($urandom % 3) == 0, 16'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
